// File: rtl/stack_drain_if.sv
// Byte-stream handshake bundle: upstream bytes into the drain controller
// and popped bytes back out.
interface stack_drain_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stack_drain.sv
// Client-side controller for a LIFO stack block: pushes an upstream byte
// stream, and on a drain request pops every entry back out in reverse order,
// waiting out the stack's read latency before presenting each byte.
//
// state  | meaning
// IDLE   | accepting bytes, pushing one per cycle; drain request starts a drain
// SETTLE | POP_LATENCY+1 cycles so the final push commits before the first pop
// POP    | issue one pop pulse (appears next cycle), decrement occupancy
// WAIT   | stk_pop cycle plus POP_LATENCY cycles; capture read data on last one
// HOLD   | byte presented on out_valid/out_data until the downstream takes it
// DONE   | one-cycle drain_done pulse, then back to IDLE
module stack_drain #(
  parameter int DEPTH       = 16,
  parameter int POP_LATENCY = 2,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  stack_drain_if.slave     sif,
  input  logic             drain,
  output logic             drain_done,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [7:0]       stk_data_in,
  input  logic [7:0]       stk_data_out,
  input  logic             stk_error,
  output logic             err
);

  // A zero-latency stack still needs a one-bit timer.
  localparam int TMR_W = (POP_LATENCY < 1) ? 1 : $clog2(POP_LATENCY + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POP_LATENCY);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_POP,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic [7:0]       din_q, din_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             accept;

  // in_ready_q is only ever high in IDLE, so this is the upstream handshake.
  assign accept = (state_q == S_IDLE) && sif.in_valid && in_ready_q;

  // Next-state and next-output logic; outputs are derived from the next
  // state so that every pin comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    din_d       = din_q;
    err_d       = err_q | stk_error;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          push_d  = 1'b1;
          din_d   = sif.in_data;
          count_d = count_q + CNT_W'(1);
        end
        // A byte accepted alongside drain is already counted above and
        // therefore included in this drain.
        if (drain) begin
          state_d = S_SETTLE;
          timer_d = TMR_LOAD;
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) begin
          state_d = (count_q == '0) ? S_DONE : S_POP;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_POP: begin
        pop_d   = 1'b1;
        count_d = count_q - CNT_W'(1);
        state_d = S_WAIT;
        timer_d = TMR_LOAD;
      end
      S_WAIT: begin
        if (timer_q == '0) begin
          out_data_d  = stk_data_out;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_HOLD: begin
        if (out_valid_q && sif.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (count_q == '0) ? S_DONE : S_POP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_IDLE) && (count_d < CNT_FULL);
  end

  // State and output registers; reset drops everything, including any byte
  // currently held on the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      din_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      din_q       <= din_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign sif.in_ready  = in_ready_q;
  assign sif.out_valid = out_valid_q;
  assign sif.out_data  = out_data_q;
  assign drain_done    = done_q;
  assign busy          = busy_q;
  assign count         = count_q;
  assign stk_push      = push_q;
  assign stk_pop       = pop_q;
  assign stk_data_in   = din_q;
  assign err           = err_q;

endmodule

// File: tb/tb_stack_drain.sv
// Bench for stack_drain: a behavioural 16-deep LIFO with a two-cycle read
// pipeline stands in for the stack block, and a queue of accepted bytes
// predicts the drained output order.
module tb_stack_drain;
  localparam int DEPTH  = 16;
  localparam int POPLAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       drain;
  logic       drain_done;
  logic       busy;
  logic [4:0] count;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out;
  logic       stk_error;
  logic       err;

  stack_drain_if sif ();

  stack_drain #(.DEPTH(DEPTH), .POP_LATENCY(POPLAT), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (rst),
    .sif          (sif),
    .drain        (drain),
    .drain_done   (drain_done),
    .busy         (busy),
    .count        (count),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_error    (stk_error),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Stack block stand-in: read data is valid only POP_LATENCY cycles after
  // the pop pulse; junk is shifted through otherwise.
  logic [7:0] mem [DEPTH];
  int         sp;
  logic [7:0] s1, s2;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= 0; s1 <= 8'h00; s2 <= 8'h00; stk_error <= 1'b0;
    end else begin
      stk_error <= 1'b0;
      if (stk_push && stk_pop) stk_error <= 1'b1;
      if (stk_push) begin
        if (sp == DEPTH) stk_error <= 1'b1;
        else begin mem[sp] <= stk_data_in; sp <= sp + 1; end
      end
      if (stk_pop) begin
        if (sp == 0) begin stk_error <= 1'b1; s1 <= 8'($urandom); end
        else begin s1 <= mem[sp-1]; sp <= sp - 1; end
      end else begin
        s1 <= 8'($urandom);
      end
      s2 <= s1;
    end
  end
  assign stk_data_out = s2;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_pop_cyc = -100;
  int         pop_count = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (stk_pop === 1'b1) begin pop_count++; last_pop_cyc = cyc; end
    chk("push_pop_exclusive", {31'd0, stk_push & stk_pop}, 32'd0);
    chk("count_le_depth", {31'd0, (count <= 5'd16)}, 32'd1);
  endtask

  // Offer one byte for one cycle (optionally with drain), then check the push.
  task automatic send(input logic [7:0] b, input bit with_drain);
    bit exp_acc;
    exp_acc = (exp_q.size() < DEPTH);
    chk("in_ready", {31'd0, sif.in_ready}, {31'd0, exp_acc});
    sif.in_valid = 1'b1;
    sif.in_data  = b;
    drain        = with_drain;
    if (exp_acc) exp_q.push_back(b);
    step();
    chk("stk_push", {31'd0, stk_push}, {31'd0, exp_acc});
    if (exp_acc) chk("stk_data_in", {24'd0, stk_data_in}, {24'd0, b});
    chk("count_after_push", {27'd0, count}, exp_q.size());
    sif.in_valid = 1'b0;
    drain        = 1'b0;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      send(8'($urandom), 1'b0);
    end
  endtask

  // Drain everything the model holds and check order, timing and pulses.
  task automatic run_drain(input bit issue, input int rdy_pct, input int hold_n, input int exp_gap);
    int         last_valid_cyc;
    int         budget;
    int         hold_cnt;
    int         idx;
    bit         r;
    logic [7:0] e;
    last_valid_cyc = -1;
    idx = 0;
    sif.out_ready = 1'b0;
    if (issue) begin
      pop_count = 0;
      drain = 1'b1;
      step();
      drain = 1'b0;
    end
    chk("busy_after_drain", {31'd0, busy}, 32'd1);
    chk("in_ready_draining", {31'd0, sif.in_ready}, 32'd0);
    if (exp_q.size() == 0) begin
      for (int i = 0; i < POPLAT + 1; i++) begin
        chk("empty_busy", {31'd0, busy}, 32'd1);
        chk("empty_done_early", {31'd0, drain_done}, 32'd0);
        step();
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_back();
      budget = 0;
      while (sif.out_valid !== 1'b1 && budget < 60) begin
        sif.out_ready = 1'($urandom_range(0, 1));
        step();
        budget++;
      end
      chk("out_valid_timeout", {31'd0, sif.out_valid}, 32'd1);
      chk("pop_to_valid", cyc - last_pop_cyc, POPLAT + 1);
      chk("one_pop_per_byte", pop_count, 32'd1);
      pop_count = 0;
      chk("count_after_pop", {27'd0, count}, exp_q.size());
      if (exp_gap > 0 && last_valid_cyc >= 0)
        chk("throughput", cyc - last_valid_cyc, exp_gap);
      last_valid_cyc = cyc;
      hold_cnt = 0;
      do begin
        chk("out_data", {24'd0, sif.out_data}, {24'd0, e});
        if (idx == 0 && hold_cnt < hold_n) r = 1'b0;
        else if (hold_cnt >= 30)           r = 1'b1;
        else                               r = ($urandom_range(0, 99) < rdy_pct);
        sif.out_ready = r;
        step();
        hold_cnt++;
        if (!r) begin
          chk("out_valid_held", {31'd0, sif.out_valid}, 32'd1);
          chk("no_pop_in_hold", pop_count, 32'd0);
        end
      end while (!r);
      chk("out_valid_drop", {31'd0, sif.out_valid}, 32'd0);
      idx++;
    end
    sif.out_ready = 1'b0;
    chk("drain_done", {31'd0, drain_done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    chk("no_extra_pop", pop_count, 32'd0);
    step();
    chk("drain_done_pulse", {31'd0, drain_done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("count_zero", {27'd0, count}, 32'd0);
    chk("in_ready_idle", {31'd0, sif.in_ready}, 32'd1);
    chk("err_clear", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst = 1'b0; drain = 1'b0;
    sif.in_valid = 1'b0; sif.in_data = 8'h00; sif.out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", {31'd0, sif.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, sif.out_valid}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_push", {31'd0, stk_push}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    step();
    chk("in_ready_after_rst", {31'd0, sif.in_ready}, 32'd1);

    // Three bytes, full-rate drain.
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    run_drain(1'b1, 100, 0, POPLAT + 3);

    // Fill to capacity, then hold a 17th byte that must not be taken.
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0);
    chk("full_in_ready", {31'd0, sif.in_ready}, 32'd0);
    chk("full_count", {27'd0, count}, 32'd16);
    sif.in_valid = 1'b1; sif.in_data = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_no_push", {31'd0, stk_push}, 32'd0);
      chk("full_count_hold", {27'd0, count}, 32'd16);
    end
    sif.in_valid = 1'b0;
    run_drain(1'b1, 100, 0, POPLAT + 3);

    // Empty drain.
    run_drain(1'b1, 100, 0, 0);

    // Downstream back-pressure on the first byte.
    send(8'hA5, 1'b0); send(8'h5A, 1'b0);
    run_drain(1'b1, 100, 10, 0);

    // Drain in the same cycle as the last accept.
    pop_count = 0;
    send(8'h01, 1'b0); send(8'h77, 1'b1);
    run_drain(1'b0, 100, 0, POPLAT + 3);

    // Random fills and random downstream readiness.
    for (int r = 0; r < 6; r++) begin
      push_rand($urandom_range(0, DEPTH));
      run_drain(1'b1, $urandom_range(20, 100), 0, 0);
    end

    // Reset while waiting on stack read data.
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
    drain = 1'b1; step(); drain = 1'b0;
    budget = 0;
    while (stk_pop !== 1'b1 && budget < 20) begin step(); budget++; end
    chk("rst_test_pop_seen", {31'd0, stk_pop}, 32'd1);
    step();
    #1 rst = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_count", {27'd0, count}, 32'd0);
    chk("async_pop", {31'd0, stk_pop}, 32'd0);
    chk("async_out_valid", {31'd0, sif.out_valid}, 32'd0);
    chk("async_out_data", {24'd0, sif.out_data}, 32'd0);
    chk("async_in_ready", {31'd0, sif.in_ready}, 32'd0);
    chk("async_done", {31'd0, drain_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("post_rst_in_ready", {31'd0, sif.in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    send(8'hC3, 1'b0);
    run_drain(1'b1, 100, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
